// File: rtl/ag_tcu_scaled_dp_pipe.sv
// Scaled integer dot-product lane: N-element signed/unsigned MAC, per-warp arithmetic
// right-shift scale and saturating accumulate, in a LATENCY-deep stallable pipeline.
module ag_tcu_scaled_dp_pipe #(
    parameter int N         = 4,
    parameter int AW        = 8,
    parameter int CW        = 32,
    parameter int LATENCY   = 3,
    parameter int NUM_WARPS = 4,
    parameter int TAGW      = 16,
    parameter int SCALE_W   = 5,
    localparam int WIDW     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDW-1:0]     in_wid,
    input  logic [TAGW-1:0]     in_tag,
    input  logic                in_mode,
    input  logic [N*AW-1:0]     in_a,
    input  logic [N*AW-1:0]     in_b,
    input  logic [CW-1:0]       in_c,
    input  logic                scale_we,
    input  logic [WIDW-1:0]     scale_wid,
    input  logic [SCALE_W-1:0]  scale_shift,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDW-1:0]     out_wid,
    output logic [TAGW-1:0]     out_tag,
    output logic [CW-1:0]       out_d,
    output logic                out_sat,
    output logic                busy
);

    localparam int SW = 2 * AW + 2 + $clog2(N);
    localparam int RW = ((CW > SW) ? CW : SW) + 1;
    localparam int PD = (LATENCY > 1) ? LATENCY - 1 : 1;

    localparam logic [RW-1:0] R_MAX  = {{(RW - CW + 1){1'b0}}, {(CW - 1){1'b1}}};
    localparam logic [RW-1:0] R_MIN  = {{(RW - CW + 1){1'b1}}, {(CW - 1){1'b0}}};
    localparam logic [CW-1:0] D_MAX  = {1'b0, {(CW - 1){1'b1}}};
    localparam logic [CW-1:0] D_MIN  = {1'b1, {(CW - 1){1'b0}}};

    typedef struct packed {
        logic [SW-1:0]      sum;
        logic [SCALE_W-1:0] shift;
        logic [CW-1:0]      c;
        logic [TAGW-1:0]    tag;
        logic [WIDW-1:0]    wid;
    } stage_t;

    logic               en_s;
    logic               accept_s;
    stage_t             front_s;
    stage_t             fin_s;
    logic               fin_v_s;
    logic [SW-1:0]      shifted_s;
    logic [RW-1:0]      acc_s;
    logic [CW-1:0]      d_s;
    logic               sat_s;

    logic [SCALE_W-1:0] scale_tbl_r [NUM_WARPS];
    stage_t             pipe_r [PD];
    logic [PD-1:0]      pvld_r;
    logic               out_valid_r;
    logic [CW-1:0]      out_d_r;
    logic               out_sat_r;
    logic [TAGW-1:0]    out_tag_r;
    logic [WIDW-1:0]    out_wid_r;

    assign en_s      = ~out_valid_r | out_ready;
    assign accept_s  = in_valid & en_s & ~flush;
    assign in_ready  = en_s & ~flush;
    assign out_valid = out_valid_r;
    assign out_d     = out_d_r;
    assign out_sat   = out_sat_r;
    assign out_tag   = out_tag_r;
    assign out_wid   = out_wid_r;
    assign busy      = out_valid_r | ((LATENCY > 1) ? (|pvld_r) : 1'b0);

    // Per-warp scale table; writes are never held off by a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                scale_tbl_r[w] <= '0;
            end
        end else if (scale_we) begin
            scale_tbl_r[scale_wid] <= scale_shift;
        end
    end

    // Stage-1 datapath: extend elements to AW+1 bits, multiply and reduce exactly at SW bits.
    always_comb begin
        logic [SW-1:0] a_x_s;
        logic [SW-1:0] b_x_s;
        front_s = '0;
        a_x_s   = '0;
        b_x_s   = '0;
        for (int i = 0; i < N; i++) begin
            a_x_s = {{(SW - AW){~in_mode & in_a[i*AW + AW - 1]}}, in_a[i*AW +: AW]};
            b_x_s = {{(SW - AW){~in_mode & in_b[i*AW + AW - 1]}}, in_b[i*AW +: AW]};
            front_s.sum = front_s.sum + a_x_s * b_x_s;
        end
        front_s.shift = scale_tbl_r[in_wid];
        front_s.c     = in_c;
        front_s.tag   = in_tag;
        front_s.wid   = in_wid;
    end

    // Final-stage operand select; with LATENCY=1 the whole datapath feeds the output register.
    always_comb begin
        if (LATENCY > 1) begin
            fin_s   = pipe_r[PD-1];
            fin_v_s = pvld_r[PD-1];
        end else begin
            fin_s   = front_s;
            fin_v_s = accept_s;
        end
    end

    // Scale, accumulate at RW bits, then clamp to the signed CW range.
    always_comb begin
        shifted_s = '0;
        acc_s     = '0;
        d_s       = '0;
        sat_s     = 1'b0;
        if (int'(fin_s.shift) >= SW) begin
            shifted_s = {SW{fin_s.sum[SW-1]}};
        end else begin
            shifted_s = $signed(fin_s.sum) >>> fin_s.shift;
        end
        acc_s = {{(RW - CW){fin_s.c[CW-1]}}, fin_s.c}
              + {{(RW - SW){shifted_s[SW-1]}}, shifted_s};
        if ($signed(acc_s) > $signed(R_MAX)) begin
            d_s   = D_MAX;
            sat_s = 1'b1;
        end else if ($signed(acc_s) < $signed(R_MIN)) begin
            d_s   = D_MIN;
            sat_s = 1'b1;
        end else begin
            d_s   = acc_s[CW-1:0];
            sat_s = 1'b0;
        end
    end

    // Valid shift register for the stages ahead of the output; flush wins over stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pvld_r <= '0;
        end else if (flush) begin
            pvld_r <= '0;
        end else if (en_s) begin
            for (int k = PD - 1; k > 0; k--) begin
                pvld_r[k] <= pvld_r[k-1];
            end
            pvld_r[0] <= accept_s;
        end
    end

    // Payload travels beside its valid bit, so metadata needs no side FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < PD; k++) begin
                pipe_r[k] <= '0;
            end
        end else if (en_s) begin
            for (int k = PD - 1; k > 0; k--) begin
                pipe_r[k] <= pipe_r[k-1];
            end
            if (accept_s) begin
                pipe_r[0] <= front_s;
            end
        end
    end

    // Output register: result fields only load with a valid op, so they hold under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_d_r     <= '0;
            out_sat_r   <= 1'b0;
            out_tag_r   <= '0;
            out_wid_r   <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (en_s) begin
            out_valid_r <= fin_v_s;
            if (fin_v_s) begin
                out_d_r   <= d_s;
                out_sat_r <= sat_s;
                out_tag_r <= fin_s.tag;
                out_wid_r <= fin_s.wid;
            end
        end
    end

endmodule

// File: tb/tb_ag_tcu_scaled_dp_pipe.sv
// Bench for ag_tcu_scaled_dp_pipe: vector table plus hand sequences, results checked
// through an in-order scoreboard fed at each accepted handshake.
module tb_ag_tcu_scaled_dp_pipe;

    localparam int N = 4, AW = 8, CW = 32, LAT = 3, NW = 4, TAGW = 16, SCW = 5;
    localparam int NV = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready, in_mode;
    logic [1:0]        in_wid;
    logic [TAGW-1:0]   in_tag;
    logic [N*AW-1:0]   in_a, in_b;
    logic [CW-1:0]     in_c;
    logic              scale_we;
    logic [1:0]        scale_wid;
    logic [SCW-1:0]    scale_shift;
    logic              flush;
    logic              out_valid, out_ready, out_sat, busy;
    logic [1:0]        out_wid;
    logic [TAGW-1:0]   out_tag;
    logic [CW-1:0]     out_d;

    typedef struct {
        logic [1:0]  wid;
        logic        mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] exp_d;
        logic        exp_sat;
    } vec_t;

    typedef struct {
        logic [31:0]     d;
        logic            sat;
        logic [TAGW-1:0] tag;
        logic [1:0]      wid;
    } exp_t;

    vec_t        vecs [NV];
    exp_t        sb [$];
    logic [4:0]  shadow [NW];
    logic [31:0] cur_exp_d;
    logic        cur_exp_sat;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_out = 0;

    ag_tcu_scaled_dp_pipe #(
        .N(N), .AW(AW), .CW(CW), .LATENCY(LAT), .NUM_WARPS(NW), .TAGW(TAGW), .SCALE_W(SCW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_tag(in_tag),
        .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .scale_we(scale_we), .scale_wid(scale_wid), .scale_shift(scale_shift),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_tag(out_tag),
        .out_d(out_d), .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] p4(input logic [7:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    // Integer reference model using the bench's shadow copy of the scale table.
    function automatic void model(input logic [1:0] wid, input logic mode,
                                  input logic [31:0] a, b, c,
                                  output logic [31:0] d, output logic sat);
        longint s = 0;
        longint ea, eb, sh, r;
        int     amt;
        for (int i = 0; i < N; i++) begin
            ea = mode ? longint'(a[i*8 +: 8]) : longint'($signed(a[i*8 +: 8]));
            eb = mode ? longint'(b[i*8 +: 8]) : longint'($signed(b[i*8 +: 8]));
            s  = s + ea * eb;
        end
        amt = int'(shadow[wid]);
        if (amt >= 20) sh = (s < 0) ? -64'sd1 : 64'sd0;
        else           sh = s >>> amt;
        r = longint'($signed(c)) + sh;
        if (r > 64'sd2147483647) begin
            d = 32'h7FFF_FFFF; sat = 1'b1;
        end else if (r < -64'sd2147483648) begin
            d = 32'h8000_0000; sat = 1'b1;
        end else begin
            d = r[31:0]; sat = 1'b0;
        end
    endfunction

    task automatic apply(input vec_t v, input logic [TAGW-1:0] tag);
        in_wid = v.wid; in_mode = v.mode; in_a = v.a; in_b = v.b; in_c = v.c;
        in_tag = tag; cur_exp_d = v.exp_d; cur_exp_sat = v.exp_sat;
    endtask

    // Hold the request until the handshake; leaves in_valid high for back-to-back use.
    task automatic send(input vec_t v, input logic [TAGW-1:0] tag);
        logic acc;
        acc = 1'b0;
        apply(v, tag);
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send_model(input logic [1:0] wid, input logic mode,
                              input logic [31:0] a, b, c, input logic [TAGW-1:0] tag);
        vec_t v;
        v.wid = wid; v.mode = mode; v.a = a; v.b = b; v.c = c;
        model(wid, mode, a, b, c, v.exp_d, v.exp_sat);
        send(v, tag);
    endtask

    task automatic write_scale(input logic [1:0] wid, input logic [4:0] sh);
        scale_we = 1'b1; scale_wid = wid; scale_shift = sh;
        @(posedge clk); #1;
        scale_we = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: output compare, hold stability, scoreboard push on accept, shadow table.
    initial begin
        exp_t            e;
        logic            hold_v;
        logic [31:0]     h_d;
        logic            h_sat;
        logic [TAGW-1:0] h_tag;
        logic [1:0]      h_wid;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                for (int w = 0; w < NW; w++) shadow[w] = 5'd0;
                hold_v = 1'b0;
            end else begin
                if (hold_v && out_valid) begin
                    chk("hold_stable", {out_sat, out_wid, out_tag, out_d}, {h_sat, h_wid, h_tag, h_d});
                end
                hold_v = out_valid && !out_ready;
                h_d = out_d; h_sat = out_sat; h_tag = out_tag; h_wid = out_wid;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 64'(sb.size()), 64'd1);
                    end else begin
                        e = sb.pop_front();
                        chk("out_d", 64'(out_d), 64'(e.d));
                        chk("out_sat", 64'(out_sat), 64'(e.sat));
                        chk("out_meta", {out_wid, out_tag}, {e.wid, e.tag});
                        n_out++;
                    end
                end
                if (flush) begin
                    sb.delete();
                end else if (in_valid && in_ready) begin
                    sb.push_back('{cur_exp_d, cur_exp_sat, in_tag, in_wid});
                end
                if (scale_we) shadow[scale_wid] = scale_shift;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   base;
        vec_t v;

        vecs[0]  = '{2'd0, 1'b0, p4(8'd1, 8'd2, 8'd3, 8'd4), p4(8'd5, 8'd6, 8'd7, 8'd8), 32'd10, 32'd80, 1'b0};
        vecs[1]  = '{2'd1, 1'b0, p4(8'h80, 8'h0, 8'h0, 8'h0), p4(8'h1, 8'h0, 8'h0, 8'h0), 32'd0, 32'hFFFF_FFE0, 1'b0};
        vecs[2]  = '{2'd1, 1'b1, p4(8'h80, 8'h0, 8'h0, 8'h0), p4(8'h1, 8'h0, 8'h0, 8'h0), 32'd0, 32'd32, 1'b0};
        vecs[3]  = '{2'd0, 1'b0, {4{8'h7F}}, {4{8'h7F}}, 32'h7FFF_FFF0, 32'h7FFF_FFFF, 1'b1};
        vecs[4]  = '{2'd0, 1'b0, {4{8'h80}}, {4{8'h7F}}, 32'h8000_0000, 32'h8000_0000, 1'b1};
        vecs[5]  = '{2'd0, 1'b1, {4{8'hFF}}, {4{8'hFF}}, 32'd0, 32'h0003_F804, 1'b0};
        vecs[6]  = '{2'd3, 1'b0, p4(8'h80, 8'h0, 8'h0, 8'h0), p4(8'h1, 8'h0, 8'h0, 8'h0), 32'd5, 32'd4, 1'b0};
        vecs[7]  = '{2'd3, 1'b1, p4(8'h80, 8'h0, 8'h0, 8'h0), p4(8'h1, 8'h0, 8'h0, 8'h0), 32'd5, 32'd5, 1'b0};
        vecs[8]  = '{2'd0, 1'b0, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
        vecs[9]  = '{2'd0, 1'b0, p4(8'h1, 8'h0, 8'h0, 8'h0), p4(8'h1, 8'h0, 8'h0, 8'h0), 32'h7FFF_FFFE, 32'h7FFF_FFFF, 1'b0};
        vecs[10] = '{2'd0, 1'b0, p4(8'h1, 8'h0, 8'h0, 8'h0), p4(8'h1, 8'h0, 8'h0, 8'h0), 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
        vecs[11] = '{2'd0, 1'b0, p4(8'hFF, 8'h0, 8'h0, 8'h0), p4(8'h1, 8'h0, 8'h0, 8'h0), 32'h8000_0000, 32'h8000_0000, 1'b1};
        vecs[12] = '{2'd0, 1'b0, p4(8'hFF, 8'h02, 8'hFD, 8'h04), p4(8'h07, 8'hFA, 8'h05, 8'hFC), 32'd100, 32'd50, 1'b0};
        vecs[13] = '{2'd1, 1'b0, p4(8'hFF, 8'h02, 8'hFD, 8'h04), p4(8'h07, 8'hFA, 8'h05, 8'hFC), 32'd0, 32'hFFFF_FFF3, 1'b0};
        vecs[14] = '{2'd1, 1'b1, p4(8'hFF, 8'h02, 8'hFD, 8'h04), p4(8'h07, 8'hFA, 8'h05, 8'hFC), 32'd0, 32'd1139, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_wid = '0; in_tag = '0; in_mode = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; scale_we = 1'b0; scale_wid = '0; scale_shift = '0;
        flush = 1'b0; out_ready = 1'b0; cur_exp_d = '0; cur_exp_sat = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_d", 64'(out_d), 64'd0);
        chk("rst_out_meta", {out_sat, out_wid, out_tag}, 64'd0);

        // Basic op with exact latency measurement.
        out_ready = 1'b1;
        apply(vecs[0], 16'h1234);
        in_valid = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(LAT));
        wait_drain();

        // Table, back-to-back.
        write_scale(2'd1, 5'd2);
        write_scale(2'd3, 5'd31);
        base = n_out;
        for (int i = 0; i < NV; i++) begin
            send(vecs[i], 16'hA000 + 16'(i));
        end
        in_valid = 1'b0;
        wait_drain();
        chk("table_count", 64'(n_out - base), 64'(NV));

        // Backpressure: 4-cycle hold from the first out_valid.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send_model(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                               $urandom, $urandom, $urandom, 16'hB000 + 16'(i));
                end
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    if (out_valid) break;
                    @(posedge clk); #1;
                end
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_in_ready", 64'(in_ready), 64'd0);
                    chk("bp_out_valid", 64'(out_valid), 64'd1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_count", 64'(n_out - base), 64'd5);

        // Flush with three ops in flight.
        out_ready = 1'b0;
        base = n_out;
        for (int i = 0; i < 3; i++) send_model(2'd1, 1'b0, $urandom, $urandom, $urandom, 16'hC000 + 16'(i));
        in_valid = 1'b0;
        chk("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("flush_no_result", 64'(n_out - base), 64'd0);

        // Asynchronous reset mid-cycle with three ops in flight.
        out_ready = 1'b0;
        base = n_out;
        for (int i = 0; i < 3; i++) send_model(2'd3, 1'b1, $urandom, $urandom, $urandom, 16'hD000 + 16'(i));
        in_valid = 1'b0;
        chk("rst_busy_before", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("arst_no_result", 64'(n_out - base), 64'd0);
        v = '{2'd1, 1'b0, p4(8'h80, 8'h0, 8'h0, 8'h0), p4(8'h1, 8'h0, 8'h0, 8'h0), 32'd0, 32'hFFFF_FF80, 1'b0};
        send(v, 16'hD100);
        v = '{2'd3, 1'b0, p4(8'h80, 8'h0, 8'h0, 8'h0), p4(8'h1, 8'h0, 8'h0, 8'h0), 32'd5, 32'hFFFF_FF85, 1'b0};
        send(v, 16'hD101);
        in_valid = 1'b0;
        wait_drain();

        // Scale write and accept to the same warp in one cycle.
        write_scale(2'd2, 5'd1);
        scale_we = 1'b1; scale_wid = 2'd2; scale_shift = 5'd3;
        v = '{2'd2, 1'b0, p4(8'd8, 8'd0, 8'd0, 8'd0), p4(8'd8, 8'd0, 8'd0, 8'd0), 32'd0, 32'd32, 1'b0};
        send(v, 16'hE000);
        scale_we = 1'b0;
        v.exp_d = 32'd8;
        send(v, 16'hE001);
        in_valid = 1'b0;
        wait_drain();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
